// File: rtl/rom_word_loader.sv
// Packs the hps_io ROM byte stream into 16-bit SDRAM word writes over a toggle req/ack port,
// stalling hps_io with ioctl_wait while a write is in flight and flagging rom_loaded at the end.
module rom_word_loader #(
  parameter logic [23:0] SDR_BASE  = 24'h000000,
  parameter logic [7:0]  ROM_INDEX = 8'd0
) (
  input  logic        CLK_32M,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic [23:0] sdr_addr,
  output logic [15:0] sdr_din,
  output logic        sdr_wrl,
  output logic        sdr_wrh,
  output logic        sdr_req,
  input  logic        sdr_ack,
  output logic        rom_loaded,
  output logic        overrun,
  output logic [24:0] byte_count
);
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FLUSH, S_DONE} state_t;

  state_t      state_q;
  logic        dl_q, fin_q, pend_valid_q;
  logic [23:0] pend_waddr_q;
  logic [7:0]  pend_lo_q;
  logic        wait_q, wrl_q, wrh_q, req_q, loaded_q, overrun_q;
  logic [23:0] addr_q;
  logic [15:0] din_q;
  logic [24:0] count_q;

  logic        acc, rise, fall, fin, pv, same_word, acked;
  logic [23:0] waddr;
  logic [24:0] count_base;

  assign acc        = ioctl_wr & ioctl_download & (ioctl_index == ROM_INDEX);
  assign rise       = ioctl_download & ~dl_q;
  assign fall       = ~ioctl_download & dl_q;
  // A new download discards any finish request and pending byte left from the previous one.
  assign fin        = (fin_q & ~rise) | fall;
  assign pv         = pend_valid_q & ~rise;
  assign waddr      = ioctl_addr[24:1] + SDR_BASE;
  assign same_word  = pv & (pend_waddr_q == waddr);
  assign acked      = (sdr_ack == req_q);
  assign count_base = rise ? 25'd0 : count_q;

  always_ff @(posedge CLK_32M) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      dl_q         <= 1'b0;
      fin_q        <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_waddr_q <= '0;
      pend_lo_q    <= '0;
      wait_q       <= 1'b0;
      addr_q       <= '0;
      din_q        <= '0;
      wrl_q        <= 1'b0;
      wrh_q        <= 1'b0;
      req_q        <= sdr_ack;
      loaded_q     <= 1'b0;
      overrun_q    <= 1'b0;
      count_q      <= '0;
    end else begin
      dl_q <= ioctl_download;
      if (rise) begin
        loaded_q     <= 1'b0;
        overrun_q    <= 1'b0;
        count_q      <= '0;
        pend_valid_q <= 1'b0;
        fin_q        <= 1'b0;
      end
      if (fall) fin_q <= 1'b1;

      case (state_q)
        S_IDLE, S_DONE: begin
          if (acc) begin
            count_q <= count_base + 25'd1;
            if (!ioctl_addr[0]) begin
              // The new even byte becomes pending right away; an older byte for another word is flushed.
              pend_valid_q <= 1'b1;
              pend_waddr_q <= waddr;
              pend_lo_q    <= ioctl_dout;
              state_q      <= S_IDLE;
              if (pv && !same_word) begin
                req_q   <= ~req_q;
                wait_q  <= 1'b1;
                addr_q  <= pend_waddr_q;
                din_q   <= {8'h00, pend_lo_q};
                wrl_q   <= 1'b1;
                wrh_q   <= 1'b0;
                state_q <= S_FLUSH;
              end
            end else begin
              req_q   <= ~req_q;
              wait_q  <= 1'b1;
              addr_q  <= waddr;
              wrh_q   <= 1'b1;
              state_q <= S_BUSY;
              if (same_word) begin
                din_q        <= {ioctl_dout, pend_lo_q};
                wrl_q        <= 1'b1;
                pend_valid_q <= 1'b0;
              end else begin
                din_q <= {ioctl_dout, 8'h00};
                wrl_q <= 1'b0;
              end
            end
          end else if (fin) begin
            if (pv) begin
              req_q        <= ~req_q;
              wait_q       <= 1'b1;
              addr_q       <= pend_waddr_q;
              din_q        <= {8'h00, pend_lo_q};
              wrl_q        <= 1'b1;
              wrh_q        <= 1'b0;
              pend_valid_q <= 1'b0;
              state_q      <= S_BUSY;
            end else begin
              state_q  <= S_DONE;
              loaded_q <= 1'b1;
              fin_q    <= 1'b0;
            end
          end else if (rise) begin
            state_q <= S_IDLE;
          end
        end
        S_BUSY: begin
          if (acc) overrun_q <= 1'b1;
          if (acked) begin
            wait_q <= 1'b0;
            if (fin && !pv) begin
              state_q  <= S_DONE;
              loaded_q <= 1'b1;
              fin_q    <= 1'b0;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        S_FLUSH: begin
          if (acc) overrun_q <= 1'b1;
          if (acked) begin
            wait_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign ioctl_wait = wait_q;
  assign sdr_addr   = addr_q;
  assign sdr_din    = din_q;
  assign sdr_wrl    = wrl_q;
  assign sdr_wrh    = wrh_q;
  assign sdr_req    = req_q;
  assign rom_loaded = loaded_q;
  assign overrun    = overrun_q;
  assign byte_count = count_q;
endmodule
